race_timer: RTL

Multi-player successor to the single-channel lap timer. Provides PLAYERS independent lap channels sharing one 0.01 s tick prescaler and one race state machine. Counts laps per player, flags finishers, picks a winner and holds results until cleared. Sits between the track/collision logic (lap_finished pulses) and the HUD/text renderer.

---
 rtl/race_timer_pkg.sv | 24 ++
 rtl/lap_channel.sv | 127 ++++++++++++
 rtl/race_timer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/race_timer_pkg.sv
// Shared race state encoding and lap-judgement helper for race_timer and lap_channel.
// Pure declarations; no logic, latency or flow control of its own.
package race_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    LAP_NONE    = 2'd0,
    LAP_VALID   = 2'd1,
    LAP_INVALID = 2'd2
  } lap_res_e;

  function automatic lap_res_e judge_lap(input logic lap, input logic overrun, input logic long_enough);
    if (!lap)                        return LAP_NONE;
    else if (long_enough && !overrun) return LAP_VALID;
    else                             return LAP_INVALID;
  endfunction

endpackage

// File: rtl/lap_channel.sv
// One player's lap clock: running/last/best time, valid lap count, overrun and finish flags.
// 1-cycle registered latency; no backpressure. TOTAL_TIME_EN adds a per-player total tick count.
module lap_channel
  import race_timer_pkg::*;
#(
  parameter int TIME_W   = 16,
  parameter int MAX_LAP  = 4000,
  parameter int MIN_LAP  = 100,
  parameter int LAPS     = 3,
  parameter int LAPCNT_W = 4
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic                run_en,
  input  logic                tick,
  input  logic                lap_pulse,
  input  logic                clear,
  output logic [TIME_W-1:0]   cur,
  output logic [TIME_W-1:0]   last,
  output logic [TIME_W-1:0]   best,
  output logic [LAPCNT_W-1:0] lap_count,
  output logic                finished,
  output logic                finish_set,
  output logic                invalid_lap
`ifdef TOTAL_TIME_EN
  ,
  output logic [TIME_W+LAPCNT_W-1:0] total_time
`endif
);

  localparam logic [TIME_W-1:0]   MAX_V  = TIME_W'(MAX_LAP);
  localparam logic [TIME_W-1:0]   MIN_V  = TIME_W'(MIN_LAP);
  localparam logic [LAPCNT_W-1:0] LAPS_V = LAPCNT_W'(LAPS);

  logic [TIME_W-1:0]   cur_q, cur_d, last_q, last_d, best_q, best_d;
  logic [LAPCNT_W-1:0] cnt_q, cnt_d;
  logic                ovr_q, ovr_d, fin_q, fin_d, inv_q, inv_d;
  lap_res_e            res;
`ifdef TOTAL_TIME_EN
  logic [TIME_W+LAPCNT_W-1:0] tot_q, tot_d;
`endif

  always_comb begin
    cur_d  = cur_q;
    last_d = last_q;
    best_d = best_q;
    cnt_d  = cnt_q;
    ovr_d  = ovr_q;
    fin_d  = fin_q;
    inv_d  = 1'b0;
    res    = judge_lap(lap_pulse, ovr_q, cur_q >= MIN_V);
`ifdef TOTAL_TIME_EN
    tot_d  = tot_q;
`endif
    if (clear) begin
      cur_d  = '0;
      last_d = '0;
      best_d = '0;
      cnt_d  = '0;
      ovr_d  = 1'b0;
      fin_d  = 1'b0;
`ifdef TOTAL_TIME_EN
      tot_d  = '0;
`endif
    end else if (run_en && !fin_q) begin
`ifdef TOTAL_TIME_EN
      if (tick) tot_d = tot_q + 1'b1;
`endif
      case (res)
        LAP_VALID: begin
          last_d = cur_q;
          if (best_q == '0 || cur_q < best_q) best_d = cur_q;
          cnt_d  = cnt_q + LAPCNT_W'(1);
          fin_d  = (cnt_d == LAPS_V);
        end
        LAP_INVALID: inv_d = 1'b1;
        default: ;
      endcase
      // A lap crossing wins over a coincident tick: the tick is simply dropped.
      if (res != LAP_NONE) begin
        cur_d = '0;
        ovr_d = 1'b0;
      end else if (tick) begin
        if (cur_q < MAX_V) cur_d = cur_q + TIME_W'(1);
        else               ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      cur_q  <= '0;
      last_q <= '0;
      best_q <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
      fin_q  <= 1'b0;
      inv_q  <= 1'b0;
`ifdef TOTAL_TIME_EN
      tot_q  <= '0;
`endif
    end else begin
      cur_q  <= cur_d;
      last_q <= last_d;
      best_q <= best_d;
      cnt_q  <= cnt_d;
      ovr_q  <= ovr_d;
      fin_q  <= fin_d;
      inv_q  <= inv_d;
`ifdef TOTAL_TIME_EN
      tot_q  <= tot_d;
`endif
    end
  end

  assign cur         = cur_q;
  assign last        = last_q;
  assign best        = best_q;
  assign lap_count   = cnt_q;
  assign finished    = fin_q;
  assign finish_set  = fin_d & ~fin_q;
  assign invalid_lap = inv_q;
`ifdef TOTAL_TIME_EN
  assign total_time  = tot_q;
`endif

endmodule

// File: rtl/race_timer.sv
// Multi-player race timer: shared 0.01 s prescaler, race FSM, per-player lap channels, winner latch.
// 1-cycle registered latency, no backpressure; TOTAL_TIME_EN adds the total_time output.
module race_timer
  import race_timer_pkg::*;
#(
  parameter int PLAYERS  = 2,
  parameter int TIME_W   = 16,
  parameter int CLK_HZ   = 65000000,
  parameter int TICK_HZ  = 100,
  parameter int MAX_LAP  = 4000,
  parameter int MIN_LAP  = 100,
  parameter int LAPS     = 3,
  parameter int LAPCNT_W = 4,
  parameter int ID_W     = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
  input  logic                         pclk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         clear,
  input  logic [PLAYERS-1:0]           lap_finished,
  output logic [PLAYERS*TIME_W-1:0]    current_lap_time,
  output logic [PLAYERS*TIME_W-1:0]    last_lap_time,
  output logic [PLAYERS*TIME_W-1:0]    best_lap_time,
  output logic [PLAYERS*LAPCNT_W-1:0]  lap_count,
  output logic [PLAYERS-1:0]           finished,
  output logic [PLAYERS-1:0]           invalid_lap,
  output logic                         running,
  output logic                         winner_valid,
  output logic [ID_W-1:0]              winner
`ifdef TOTAL_TIME_EN
  ,
  output logic [PLAYERS*(TIME_W+LAPCNT_W)-1:0] total_time
`endif
);

  localparam int              TC    = CLK_HZ / TICK_HZ - 1;
  localparam int              PRE_W = (TC > 0) ? $clog2(TC + 1) : 1;
  localparam logic [PRE_W-1:0] TC_V = PRE_W'(TC);

  state_e              state_q, state_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                wv_q, wv_d;
  logic [ID_W-1:0]     win_q, win_d;
  logic                tick, run_en;
  logic [PLAYERS-1:0]  fin_set;

  assign run_en = (state_q == RUN);
  assign tick   = run_en && (pre_q == TC_V);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    wv_d    = wv_q;
    win_d   = win_q;
    if (clear) begin
      state_d = IDLE;
      pre_d   = '0;
      wv_d    = 1'b0;
      win_d   = '0;
    end else begin
      case (state_q)
        IDLE:    if (start && !stop) state_d = RUN;
        RUN:     if (stop) state_d = PAUSED;
                 else if (&finished) state_d = DONE;
        PAUSED:  if (start && !stop) state_d = RUN;
        default: ;
      endcase
      // Phase is held outside RUN so a resume continues the interrupted tick period.
      if (run_en) pre_d = tick ? '0 : pre_q + PRE_W'(1);
      if (!wv_q && |fin_set) begin
        wv_d = 1'b1;
        for (int i = PLAYERS - 1; i >= 0; i--) begin
          if (fin_set[i]) win_d = ID_W'(i);
        end
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      wv_q    <= 1'b0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      wv_q    <= wv_d;
      win_q   <= win_d;
    end
  end

  for (genvar g = 0; g < PLAYERS; g++) begin : g_ch
    lap_channel #(
      .TIME_W  (TIME_W),
      .MAX_LAP (MAX_LAP),
      .MIN_LAP (MIN_LAP),
      .LAPS    (LAPS),
      .LAPCNT_W(LAPCNT_W)
    ) u_ch (
      .pclk       (pclk),
      .rst        (rst),
      .run_en     (run_en),
      .tick       (tick),
      .lap_pulse  (lap_finished[g]),
      .clear      (clear),
      .cur        (current_lap_time[g*TIME_W +: TIME_W]),
      .last       (last_lap_time[g*TIME_W +: TIME_W]),
      .best       (best_lap_time[g*TIME_W +: TIME_W]),
      .lap_count  (lap_count[g*LAPCNT_W +: LAPCNT_W]),
      .finished   (finished[g]),
      .finish_set (fin_set[g]),
      .invalid_lap(invalid_lap[g])
`ifdef TOTAL_TIME_EN
      ,
      .total_time (total_time[g*(TIME_W+LAPCNT_W) +: (TIME_W+LAPCNT_W)])
`endif
    );
  end

  assign running      = run_en;
  assign winner_valid = wv_q;
  assign winner       = win_q;

endmodule
